// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter; define UART_TX_PARITY_EN to insert an even-parity bit.
module uart_tx #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Tx_DV,
    input  logic [7:0] i_Tx_Byte,
    output logic       o_Tx_Ready,
    output logic       o_Tx_Active,
    output logic       o_Tx_Serial,
    output logic       o_Tx_Done
);

    localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY  = 3'd3,
`endif
        STOP    = 3'd4,
        CLEANUP = 3'd5
    } state_t;

    // Declaration initialisers give the idle-high line before the first reset.
    state_t     state_q  = IDLE;
    state_t     state_d;
    logic [7:0] cnt_q    = '0;
    logic [7:0] cnt_d;
    logic [2:0] idx_q    = '0;
    logic [2:0] idx_d;
    logic [7:0] data_q   = '0;
    logic [7:0] data_d;
    logic       serial_q = 1'b1;
    logic       serial_d;
    logic       active_q = 1'b0;
    logic       active_d;
    logic       done_q   = 1'b0;
    logic       done_d;
    logic       ready_q  = 1'b1;
    logic       ready_d;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            serial_q <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            serial_q <= serial_d;
            active_q <= active_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
        end
    end

    // Outputs are computed for the next state so the registered line changes on the same edge as the state.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        data_d   = data_q;
        serial_d = serial_q;
        active_d = active_q;
        done_d   = 1'b0;
        ready_d  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d    = '0;
                idx_d    = '0;
                serial_d = 1'b1;
                active_d = 1'b0;
                ready_d  = 1'b1;
                if (i_Tx_DV) begin
                    data_d   = i_Tx_Byte;
                    state_d  = START;
                    serial_d = 1'b0;
                    active_d = 1'b1;
                    ready_d  = 1'b0;
                end
            end
            START: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d    = '0;
                    state_d  = DATA;
                    serial_d = data_q[0];
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DATA: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d  = PARITY;
                        serial_d = ^data_q;
`else
                        state_d  = STOP;
                        serial_d = 1'b1;
`endif
                    end else begin
                        serial_d = data_q[idx_q + 3'd1];
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d    = '0;
                    state_d  = STOP;
                    serial_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
`endif
            STOP: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d    = '0;
                    state_d  = CLEANUP;
                    serial_d = 1'b1;
                    active_d = 1'b0;
                    done_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            CLEANUP: begin
                state_d  = IDLE;
                serial_d = 1'b1;
                active_d = 1'b0;
                ready_d  = 1'b1;
            end
            default: begin
                state_d  = IDLE;
                cnt_d    = '0;
                idx_d    = '0;
                serial_d = 1'b1;
                active_d = 1'b0;
                ready_d  = 1'b1;
            end
        endcase
    end

    assign o_Tx_Serial = serial_q;
    assign o_Tx_Active = active_q;
    assign o_Tx_Done   = done_q;
    assign o_Tx_Ready  = ready_q;

endmodule
